// File: rtl/palette_update_ctrl.sv
// Writable 16-entry RGB palette: host writes queue up and commit only during vertical blank,
// plus a frame-counted hit-flash overlay. Optional `transparent` output under PALETTE_TRANSPARENT_EN.
module palette_update_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_IDX    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [3:0]  wr_idx,
    input  logic [11:0] wr_rgb,
    output logic        wr_ack,
    input  logic        blank,
    input  logic        flash_start,
    output logic        flash_busy,
    output logic [2:0]  pending,
    input  logic [3:0]  pix_idx,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
`ifdef PALETTE_TRANSPARENT_EN
    output logic        transparent,
`endif
    output logic        dbg_state
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [3:0] FIDX = 4'(FLASH_IDX);

    typedef enum logic {IDLE, COMMIT} state_t;

    // Handshake: a write is taken on any cycle where wr_req && wr_ack are both high.
    logic [3:0]    q_idx [QDEPTH];
    logic [11:0]   q_rgb [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [11:0]   pal [16];
    logic [FW-1:0] flash_cnt;
    logic          blank_q;
    state_t        state;

    logic push, pop, frame_tick, flash_on;

    assign wr_ack     = (count != CW'(QDEPTH));
    assign pending    = 3'(count);
    assign push       = wr_req && wr_ack;
    assign pop        = blank && (count != '0);
    assign frame_tick = blank && !blank_q;
    assign flash_on   = flash_busy && flash_cnt[0];
    assign dbg_state  = (state == COMMIT);

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= wr_idx;
            q_rgb[wr_ptr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The FSM is informational: the pop itself follows blank && non-empty in either state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (blank && count != '0) state <= COMMIT;
                COMMIT:  if (!blank || count == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                pal[i] <= (i == 1) ? 12'hF00 : 12'h0F0;
        end else if (pop) begin
            pal[q_idx[rd_ptr]] <= q_rgb[rd_ptr];
        end
    end

    // A flash_start load takes priority over a simultaneous frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q    <= 1'b0;
            flash_cnt  <= '0;
            flash_busy <= 1'b0;
        end else begin
            blank_q <= blank;
            if (flash_start) begin
                flash_cnt  <= FW'(FLASH_FRAMES);
                flash_busy <= 1'b1;
            end else if (frame_tick && flash_busy) begin
                flash_cnt <= flash_cnt - 1'b1;
                if (flash_cnt == FW'(1)) flash_busy <= 1'b0;
            end
        end
    end

    // Palette read sees the pre-commit value when a commit hits the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
        end else begin
            {red, green, blue} <= flash_on ? pal[FIDX] : pal[pix_idx];
        end
    end

`ifdef PALETTE_TRANSPARENT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) transparent <= 1'b0;
        else       transparent <= (pix_idx == 4'd0);
    end
`endif

endmodule

// File: tb/tb_palette_update_ctrl.sv
// Scoreboard bench for palette_update_ctrl: queue/array reference model, directed scenarios, random traffic.
module tb_palette_update_ctrl;
    localparam int QD = 4;
    localparam int FF = 8;
    localparam int FI = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        wr_ack;
    logic        blank = 1'b0;
    logic        flash_start = 1'b0;
    logic        flash_busy;
    logic [2:0]  pending;
    logic [3:0]  pix_idx = '0;
    logic [3:0]  red, green, blue;
    logic        dbg_state;
`ifdef PALETTE_TRANSPARENT_EN
    logic        transparent;
`endif

    palette_update_ctrl #(.QDEPTH(QD), .FLASH_FRAMES(FF), .FLASH_IDX(FI)) dut (
        .clk(clk), .reset(rst),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .wr_ack(wr_ack),
        .blank(blank), .flash_start(flash_start), .flash_busy(flash_busy),
        .pending(pending), .pix_idx(pix_idx),
        .red(red), .green(green), .blue(blue),
`ifdef PALETTE_TRANSPARENT_EN
        .transparent(transparent),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: palette array, pending writes as a queue, flash as a frame countdown.
    logic [11:0] m_pal [16];
    logic [15:0] m_q[$];
    int          m_cnt;
    bit          m_busy;
    bit          m_blank_prev;
    bit          m_transp;
    logic [11:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = (i == 1) ? 12'hF00 : 12'h0F0;
        m_q.delete();
        m_cnt = 0;
        m_busy = 0;
        m_blank_prev = 0;
        m_transp = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            logic [15:0] e;
            bit accept;
            exp_q.push_back((m_busy && (m_cnt % 2 == 1)) ? m_pal[FI] : m_pal[pix_idx]);
            m_transp = (pix_idx == 0);
            accept = wr_req && (m_q.size() < QD);
            if (blank && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_pal[e[15:12]] = e[11:0];
            end
            if (accept) m_q.push_back({wr_idx, wr_rgb});
            if (flash_start) begin
                m_cnt = FF;
                m_busy = 1;
            end else if (blank && !m_blank_prev && m_busy) begin
                m_cnt = m_cnt - 1;
                m_busy = (m_cnt != 0);
            end
            m_blank_prev = blank;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rgb", {20'd0, red, green, blue}, 32'h000);
            chk("rst_pending", {29'd0, pending}, 32'd0);
            chk("rst_wr_ack", {31'd0, wr_ack}, 32'd1);
            chk("rst_flash_busy", {31'd0, flash_busy}, 32'd0);
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0)
                chk("sb_rgb", {20'd0, red, green, blue}, {20'd0, exp_q.pop_front()});
            chk("sb_pending", {29'd0, pending}, m_q.size());
            chk("sb_wr_ack", {31'd0, wr_ack}, {31'd0, (m_q.size() < QD)});
            chk("sb_flash_busy", {31'd0, flash_busy}, {31'd0, m_busy});
`ifdef PALETTE_TRANSPARENT_EN
            chk("sb_transparent", {31'd0, transparent}, {31'd0, m_transp});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] idx, input logic [11:0] rgb);
        wr_req = 1'b1;
        wr_idx = idx;
        wr_rgb = rgb;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic blank_for(input int n);
        blank = 1'b1;
        repeat (n) tick();
        blank = 1'b0;
    endtask

    initial begin
        // Reset release, then default palette lookups.
        repeat (3) tick();
        rst = 1'b0;
        pix_idx = 4'd1;
        tick();
        chk("rgb_idx1", {20'd0, red, green, blue}, 32'hF00);
        pix_idx = 4'd5;
        tick();
        chk("rgb_idx5", {20'd0, red, green, blue}, 32'h0F0);

        // Fill queue outside blank; fifth write must be dropped.
        write(4'd3, 12'h00F);
        write(4'd4, 12'h111);
        write(4'd6, 12'h222);
        write(4'd8, 12'h333);
        chk("full_pending", {29'd0, pending}, 32'd4);
        chk("full_wr_ack", {31'd0, wr_ack}, 32'd0);
        write(4'd3, 12'hEEE);
        chk("drop_pending", {29'd0, pending}, 32'd4);
        pix_idx = 4'd3;
        tick();
        chk("pre_commit_idx3", {20'd0, red, green, blue}, 32'h0F0);
        blank_for(4);
        chk("drain_pending", {29'd0, pending}, 32'd0);
        tick();
        chk("post_commit_idx3", {20'd0, red, green, blue}, 32'h00F);

        // Same index twice: arrival order, last wins.
        write(4'd7, 12'hABC);
        write(4'd7, 12'h123);
        blank_for(2);
        pix_idx = 4'd7;
        tick();
        chk("last_wins_idx7", {20'd0, red, green, blue}, 32'h123);

        // Short blank commits one entry; the rest wait for the next blank.
        write(4'd9, 12'h456);
        write(4'd10, 12'h567);
        write(4'd11, 12'h678);
        blank_for(1);
        chk("partial_pending", {29'd0, pending}, 32'd2);
        tick();
        blank_for(2);
        chk("rest_pending", {29'd0, pending}, 32'd0);

        // Flash over eight frame ticks, looking up entry 5.
        pix_idx = 4'd5;
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        chk("flash_busy_set", {31'd0, flash_busy}, 32'd1);
        for (int k = 1; k <= FF; k++) begin
            blank_for(2);
            repeat (3) tick();
            chk("flash_rgb", {20'd0, red, green, blue}, ((FF - k) % 2 == 1) ? 32'hF00 : 32'h0F0);
            chk("flash_busy", {31'd0, flash_busy}, (k < FF) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset while committing with two entries left.
        write(4'd1, 12'h0AB);
        write(4'd1, 12'h0CD);
        write(4'd2, 12'h0EF);
        blank_for(1);
        chk("mid_commit_pending", {29'd0, pending}, 32'd2);
        chk("mid_commit_state", {31'd0, dbg_state}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pending", {29'd0, pending}, 32'd0);
        chk("async_rst_wr_ack", {31'd0, wr_ack}, 32'd1);
        chk("async_rst_state", {31'd0, dbg_state}, 32'd0);
        tick();
        rst = 1'b0;
        pix_idx = 4'd1;
        tick();
        chk("after_rst_idx1", {20'd0, red, green, blue}, 32'hF00);
        pix_idx = 4'd2;
        tick();
        chk("after_rst_idx2", {20'd0, red, green, blue}, 32'h0F0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            wr_req = ($urandom_range(0, 2) == 0);
            wr_idx = 4'($urandom_range(0, 15));
            wr_rgb = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) blank = ~blank;
            flash_start = ($urandom_range(0, 39) == 0);
            pix_idx = 4'($urandom_range(0, 15));
            tick();
        end
        wr_req = 1'b0;
        flash_start = 1'b0;
        blank = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/palette_update_ctrl.md
Name: palette_update_ctrl

Overview:
- Owns the 16-entry 12-bit RGB palette used by the tile renderers.
- Replaces the fixed ROM palette with a writable active palette.
- Host palette writes are queued and committed only during vertical blanking, so colours never change mid-frame.
- Also sequences a frame-counted "hit flash" effect. Sits between the game-logic write source and the pixel colour mux.

Parameters:
- QDEPTH, 4, depth of the pending-write queue (power of two, ≥2)
- FLASH_FRAMES, 8, number of frames a flash lasts
- FLASH_IDX, 1, palette entry whose colour is shown on "on" flash frames

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- wr_req  in  1  host requests a palette write
- wr_idx  in  4  entry to write
- wr_rgb  in  12  new colour {R,G,B}, 4 bits each
- wr_ack  out  1  queue not full; a write is accepted on a cycle with wr_req && wr_ack
- blank  in  1  vertical-blank level from the VGA controller
- flash_start  in  1  single-cycle pulse that starts or restarts a flash
- flash_busy  out  1  flash sequence active
- pending  out  3  number of queued, uncommitted writes (0..QDEPTH)
- pix_idx  in  4  pixel palette index
- red, green, blue  out  4 each  looked-up colour, registered

Behaviour:
- Reset values of the active palette:
  - entry 0 = {0,F,0}
  - entry 1 = {F,0,0}
  - entries 2..15 = {0,F,0}
- Reset values of outputs and state: queue empty; pending=0; wr_ack=1; flash_busy=0; red/green/blue=0; FSM=IDLE; flash counter=0.
- Queue:
  - Circular FIFO of {idx,rgb}.
  - wr_ack = (pending != QDEPTH), combinational from registered count.
  - When full, wr_req is ignored and no data is lost or overwritten.
- Commit FSM:
  - IDLE → COMMIT when blank=1 and pending>0.
  - In COMMIT, one queue entry is popped and written to the active palette per cycle.
  - COMMIT → IDLE when the queue becomes empty or blank=0. Remaining entries wait for the next blank.
  - A push and a pop in the same cycle leave pending unchanged.
  - Writes to the same index commit in arrival order; the last one wins.
- Lookup:
  - Colour = active[pix_idx] registered, giving 1-cycle latency.
  - If a commit writes the entry being looked up in the same cycle, the old value is output (read-before-write). The new value appears from the next lookup.
- Flash:
  - A frame tick is the rising edge of blank, detected with a registered copy of blank.
  - flash_start loads the counter with FLASH_FRAMES and sets flash_busy=1 from the next cycle.
  - Each frame tick decrements the counter; flash_busy clears when it reaches 0.
  - While busy and counter[0]=1 ("on" frame), every lookup returns active[FLASH_IDX]. Otherwise the normal lookup is used.
  - flash_start during an active flash restarts the count.
  - flash_start coinciding with a frame tick: the load wins.
- Reset asserted mid-operation (asynchronous):
  - Queue flushed, palette restored to default values, flash aborted.
  - All outputs take their reset values immediately.

Optional Feature:
- Macro: PALETTE_TRANSPARENT_EN.
- When defined:
  - Extra output port transparent (out, 1) = registered (pix_idx == 0), aligned with the colour output.
  - transparent resets to 0.
  - transparent is unaffected by flash.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with pix_idx=1, then pix_idx=5 on following cycles → rgb {F,0,0}, then {0,F,0}, each 1 cycle after its index.
- Four writes (idx 3 = 0x00F) with blank=0 → pending=4, wr_ack=0; a fifth wr_req is dropped. Lookup idx 3 still returns 0x0F0. After blank=1 for 4 cycles → pending=0 and lookup returns 0x00F.
- Two queued writes to idx 7 (0xABC then 0x123), blank=1 → idx 7 reads 0x123.
- Three queued writes, blank=1 for 1 cycle only → pending=2. The next blank drains the rest.
- flash_start with FLASH_FRAMES=8 → flash_busy stays 1 for 8 blank rising edges. Lookups of idx 5 return 0xF00 on odd-count frames and 0x0F0 on even-count frames. flash_busy=0 after the 8th edge.
- Reset asserted during COMMIT with 2 entries pending → pending=0, wr_ack=1, entry 1 reads 0xF00 after release, no partial commit remains.
